// File: rtl/lcd_window_ctrl_if.sv
// lcd_window_ctrl_if: request, pixel-source and serializer byte link of the LCD window controller
interface lcd_window_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  x0;
  logic [7:0]  x1;
  logic [7:0]  y0;
  logic [7:0]  y1;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic [7:0]  tx_data;
  logic        tx_rs;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        done;
  logic        err;
  modport master (
    output req_valid, x0, x1, y0, y1, pix_data, pix_valid, tx_ready,
    input  req_ready, pix_ready, tx_data, tx_rs, tx_valid, busy, done, err
  );
  modport slave (
    input  req_valid, x0, x1, y0, y1, pix_data, pix_valid, tx_ready,
    output req_ready, pix_ready, tx_data, tx_rs, tx_valid, busy, done, err
  );
endinterface

// File: rtl/lcd_window_ctrl.sv
// lcd_window_ctrl: emits CASET/RASET/RAMWR header then RGB565 pixel byte pairs for a window write
module lcd_window_ctrl #(
  parameter int         WIDTH  = 128,
  parameter int         HEIGHT = 160,
  parameter logic [7:0] CASET  = 8'h2A,
  parameter logic [7:0] RASET  = 8'h2B,
  parameter logic [7:0] RAMWR  = 8'h2C
) (
  input logic cin,
  input logic reset,
  lcd_window_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, HDR, PIX_WAIT, PIX_HI, PIX_LO} state_t;
  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d, idx_n;
  logic [14:0] count_q, count_d;
  logic [7:0]  x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d;
  logic [7:0]  lo_q, lo_d, tx_data_q, tx_data_d, hdr_byte;
  logic        tx_rs_q, tx_rs_d, tx_valid_q, tx_valid_d, done_q, done_d, err_q, err_d;
  logic        bad, fire, hdr_rs;
  logic [8:0]  w, h;
  assign w      = 9'(bus.x1) - 9'(bus.x0) + 9'd1;
  assign h      = 9'(bus.y1) - 9'(bus.y0) + 9'd1;
  assign bad    = (bus.x0 > bus.x1) || (bus.y0 > bus.y1) || (32'(bus.x1) >= WIDTH) || (32'(bus.y1) >= HEIGHT);
  assign fire   = tx_valid_q && bus.tx_ready;
  assign idx_n  = idx_q + 4'd1;
  assign hdr_rs = !(idx_n == 4'd5 || idx_n == 4'd10);
  assign bus.req_ready = state_q == IDLE;
  assign bus.pix_ready = state_q == PIX_WAIT;
  assign bus.busy      = state_q != IDLE;
  assign bus.tx_data   = tx_data_q;
  assign bus.tx_rs     = tx_rs_q;
  assign bus.tx_valid  = tx_valid_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  // header byte that follows the current index: zero high bytes between the opcodes and coordinates
  always_comb begin
    case (idx_n)
      4'd2:    hdr_byte = x0_q;
      4'd4:    hdr_byte = x1_q;
      4'd5:    hdr_byte = RASET;
      4'd7:    hdr_byte = y0_q;
      4'd9:    hdr_byte = y1_q;
      4'd10:   hdr_byte = RAMWR;
      default: hdr_byte = 8'h00;
    endcase
  end
  // next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    count_d    = count_q;
    x0_d       = x0_q;
    x1_d       = x1_q;
    y0_d       = y0_q;
    y1_d       = y1_q;
    lo_d       = lo_q;
    tx_data_d  = tx_data_q;
    tx_rs_d    = tx_rs_q;
    tx_valid_d = tx_valid_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        x0_d = bus.x0;
        x1_d = bus.x1;
        y0_d = bus.y0;
        y1_d = bus.y1;
        if (bad) err_d = 1'b1;
        else begin
          state_d    = HDR;
          idx_d      = 4'd0;
          count_d    = 15'(w) * 15'(h);
          tx_valid_d = 1'b1;
          tx_data_d  = CASET;
          tx_rs_d    = 1'b0;
        end
      end
      HDR: if (fire) begin
        if (idx_q == 4'd10) begin
          tx_valid_d = 1'b0;
          state_d    = PIX_WAIT;
        end else begin
          idx_d     = idx_n;
          tx_data_d = hdr_byte;
          tx_rs_d   = hdr_rs;
        end
      end
      PIX_WAIT: if (bus.pix_valid) begin
        lo_d       = bus.pix_data[7:0];
        tx_data_d  = bus.pix_data[15:8];
        tx_rs_d    = 1'b1;
        tx_valid_d = 1'b1;
        state_d    = PIX_HI;
      end
      PIX_HI: if (fire) begin
        tx_data_d = lo_q;
        state_d   = PIX_LO;
      end
      PIX_LO: if (fire) begin
        tx_valid_d = 1'b0;
        count_d    = count_q - 15'd1;
        done_d     = count_q == 15'd1;
        state_d    = count_q == 15'd1 ? IDLE : PIX_WAIT;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and output registers; reset abandons any window in flight
  always_ff @(posedge cin or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      count_q    <= '0;
      x0_q       <= '0;
      x1_q       <= '0;
      y0_q       <= '0;
      y1_q       <= '0;
      lo_q       <= '0;
      tx_data_q  <= '0;
      tx_rs_q    <= 1'b0;
      tx_valid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      count_q    <= count_d;
      x0_q       <= x0_d;
      x1_q       <= x1_d;
      y0_q       <= y0_d;
      y1_q       <= y1_d;
      lo_q       <= lo_d;
      tx_data_q  <= tx_data_d;
      tx_rs_q    <= tx_rs_d;
      tx_valid_q <= tx_valid_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end
endmodule

// File: tb/tb_lcd_window_ctrl.sv
// tb_lcd_window_ctrl: vector table plus scoreboard of expected serializer bytes for lcd_window_ctrl
module tb_lcd_window_ctrl;
  logic cin = 1'b0;
  logic reset = 1'b1;
  lcd_window_ctrl_if ifc();
  lcd_window_ctrl dut (.cin(cin), .reset(reset), .bus(ifc));
  always #5 cin = ~cin;

  typedef struct {
    logic [7:0] x0;
    logic [7:0] x1;
    logic [7:0] y0;
    logic [7:0] y1;
    bit         bad;
  } vec_t;

  vec_t       vecs[8];
  logic [8:0] exp_q[$];
  logic [8:0] mon_e;
  logic [15:0] mon_p;
  int passed = 0;
  int total = 0;
  int pix_cnt = 0;
  int pix_hs = 0;
  int tx_cnt = 0;
  bit tx_rand = 1'b0;
  bit tx_force = 1'b1;
  bit pix_en = 1'b1;
  bit pix_rand = 1'b0;

  function automatic logic [15:0] pat(input int n);
    return 16'hF81F ^ 16'(n * 32'h2B3D);
  endfunction

  function automatic void chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
  endfunction

  // input driver: updates a little after each rising edge
  always @(posedge cin) begin
    #1;
    ifc.tx_ready  = tx_rand ? ($urandom_range(0, 3) != 0) : tx_force;
    ifc.pix_data  = pat(pix_cnt);
    ifc.pix_valid = pix_en && (!pix_rand || $urandom_range(0, 2) != 0);
  end

  // monitor: handshakes seen on the falling edge complete on the next rising edge
  always @(negedge cin) begin
    if (!reset) begin
      if (ifc.tx_valid && ifc.tx_ready) begin
        tx_cnt++;
        if (exp_q.size() == 0) chk(1'b0, "unexpected_byte", {ifc.tx_data, ifc.tx_rs}, 0);
        else begin
          mon_e = exp_q.pop_front();
          chk({ifc.tx_data, ifc.tx_rs} == mon_e, "tx_byte", {ifc.tx_data, ifc.tx_rs}, mon_e);
        end
      end
      if (ifc.pix_valid && ifc.pix_ready) begin
        mon_p = pat(pix_cnt);
        exp_q.push_back({mon_p[15:8], 1'b1});
        exp_q.push_back({mon_p[7:0], 1'b1});
        pix_cnt++;
        pix_hs++;
      end
    end
  end

  task automatic push_hdr(input vec_t v);
    exp_q.push_back({8'h2A, 1'b0});
    exp_q.push_back({8'h00, 1'b1});
    exp_q.push_back({v.x0, 1'b1});
    exp_q.push_back({8'h00, 1'b1});
    exp_q.push_back({v.x1, 1'b1});
    exp_q.push_back({8'h2B, 1'b0});
    exp_q.push_back({8'h00, 1'b1});
    exp_q.push_back({v.y0, 1'b1});
    exp_q.push_back({8'h00, 1'b1});
    exp_q.push_back({v.y1, 1'b1});
    exp_q.push_back({8'h2C, 1'b0});
  endtask

  task automatic drive_req(input vec_t v);
    ifc.x0 = v.x0;
    ifc.x1 = v.x1;
    ifc.y0 = v.y0;
    ifc.y1 = v.y1;
    ifc.req_valid = 1'b1;
    @(negedge cin);
    ifc.req_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk(ifc.tx_valid == 1'b0, {tag, "_tx_valid"}, ifc.tx_valid, 0);
    chk(ifc.tx_data == 8'h00, {tag, "_tx_data"}, ifc.tx_data, 0);
    chk(ifc.tx_rs == 1'b0, {tag, "_tx_rs"}, ifc.tx_rs, 0);
    chk(ifc.pix_ready == 1'b0, {tag, "_pix_ready"}, ifc.pix_ready, 0);
    chk(ifc.busy == 1'b0, {tag, "_busy"}, ifc.busy, 0);
    chk(ifc.done == 1'b0, {tag, "_done"}, ifc.done, 0);
    chk(ifc.err == 1'b0, {tag, "_err"}, ifc.err, 0);
    chk(ifc.req_ready == 1'b1, {tag, "_req_ready"}, ifc.req_ready, 1);
  endtask

  task automatic run_req(input vec_t v, input int budget);
    int t, hs0, tx0, np;
    np = (int'(v.x1) - int'(v.x0) + 1) * (int'(v.y1) - int'(v.y0) + 1);
    t = 0;
    while (!ifc.req_ready && t < 100) begin
      @(negedge cin);
      t++;
    end
    chk(ifc.req_ready, "req_ready_idle", ifc.req_ready, 1);
    if (!v.bad) push_hdr(v);
    hs0 = pix_hs;
    tx0 = tx_cnt;
    drive_req(v);
    chk(ifc.err == v.bad, "err_pulse", ifc.err, v.bad);
    chk(ifc.tx_valid == !v.bad, "first_tx_valid", ifc.tx_valid, !v.bad);
    if (v.bad) begin
      @(negedge cin);
      chk(ifc.err == 1'b0, "err_single", ifc.err, 0);
      chk(ifc.tx_valid == 1'b0 && ifc.busy == 1'b0, "err_no_tx", {ifc.tx_valid, ifc.busy}, 0);
    end else begin
      chk(ifc.busy == 1'b1, "busy_hdr", ifc.busy, 1);
      t = 0;
      while (!ifc.done && t < budget) begin
        @(negedge cin);
        t++;
      end
      chk(ifc.done == 1'b1, "done_seen", t, budget);
      chk(ifc.err == 1'b0 && ifc.req_ready == 1'b1, "idle_at_done", {ifc.err, ifc.req_ready}, 1);
      chk(pix_hs - hs0 == np, "pix_count", pix_hs - hs0, np);
      chk(tx_cnt - tx0 == 11 + 2 * np, "byte_count", tx_cnt - tx0, 11 + 2 * np);
      chk(exp_q.size() == 0, "queue_empty", exp_q.size(), 0);
      exp_q.delete();
      @(negedge cin);
      chk(ifc.done == 1'b0, "done_single", ifc.done, 0);
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int t, base;
    logic [15:0] p16;
    logic [7:0] hold;
    ifc.req_valid = 1'b0;
    ifc.x0 = '0;
    ifc.x1 = '0;
    ifc.y0 = '0;
    ifc.y1 = '0;
    vecs[0] = '{8'd5, 8'd5, 8'd7, 8'd7, 1'b0};
    vecs[1] = '{8'd10, 8'd9, 8'd0, 8'd0, 1'b1};
    vecs[2] = '{8'd0, 8'd0, 8'd0, 8'd160, 1'b1};
    vecs[3] = '{8'd0, 8'd128, 8'd0, 8'd0, 1'b1};
    vecs[4] = '{8'd0, 8'd0, 8'd5, 8'd4, 1'b1};
    vecs[5] = '{8'd2, 8'd4, 8'd3, 8'd4, 1'b0};
    vecs[6] = '{8'd127, 8'd127, 8'd159, 8'd159, 1'b0};
    vecs[7] = '{8'd0, 8'd7, 8'd0, 8'd1, 1'b0};
    repeat (2) @(negedge cin);
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge cin);
    chk(ifc.req_ready == 1'b1, "req_ready_post_reset", ifc.req_ready, 1);

    for (int i = 0; i < 8; i++) begin
      tx_rand  = (i != 0);
      pix_rand = (i != 0);
      run_req(vecs[i], 2000);
    end

    tx_rand  = 1'b0;
    pix_rand = 1'b0;
    run_req('{8'd0, 8'd127, 8'd0, 8'd159, 1'b0}, 70000);

    tx_force = 1'b0;
    @(negedge cin);
    @(negedge cin);
    v = '{8'd3, 8'd4, 8'd1, 8'd1, 1'b0};
    base = pix_cnt;
    p16 = pat(base);
    push_hdr(v);
    drive_req(v);
    for (int k = 0; k < 15; k++) begin
      t = 0;
      while (!ifc.tx_valid && t < 50) begin
        @(negedge cin);
        t++;
      end
      chk(ifc.tx_valid == 1'b1, "stall_wait_valid", t, 50);
      if (k == 2 || k == 12) begin
        hold = (k == 2) ? 8'd3 : p16[7:0];
        repeat (5) begin
          @(negedge cin);
          chk({ifc.tx_data, ifc.tx_rs, ifc.tx_valid} == {hold, 2'b11}, "stall_hold",
              {ifc.tx_data, ifc.tx_rs, ifc.tx_valid}, {hold, 2'b11});
        end
      end
      tx_force = 1'b1;
      @(negedge cin);
      tx_force = 1'b0;
      @(negedge cin);
    end
    t = 0;
    while (!ifc.done && t < 20) begin
      @(negedge cin);
      t++;
    end
    chk(ifc.done == 1'b1, "stall_done", t, 20);
    chk(exp_q.size() == 0, "stall_queue_empty", exp_q.size(), 0);
    exp_q.delete();

    tx_force = 1'b1;
    @(negedge cin);
    @(negedge cin);
    v = '{8'd0, 8'd3, 8'd0, 8'd3, 1'b0};
    push_hdr(v);
    drive_req(v);
    repeat (30) @(negedge cin);
    chk(ifc.busy == 1'b1, "busy_before_reset", ifc.busy, 1);
    @(posedge cin);
    #3;
    reset = 1'b1;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    @(negedge cin);
    reset = 1'b0;
    @(negedge cin);
    chk(ifc.req_ready == 1'b1, "req_ready_after_midreset", ifc.req_ready, 1);
    run_req('{8'd20, 8'd20, 8'd30, 8'd30, 1'b0}, 200);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
